// File: rtl/systolic_feed_ctrl_pkg.sv
// Shared definitions for the systolic-array feed path: sequencer states,
// common size defaults and the lane-slice helper.
package systolic_feed_ctrl_pkg;

  localparam int unsigned FEED_N_DEF     = 3;
  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned DEPTH_DEF      = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    LOAD,
    POST,
    FEED,
    DRAIN
  } feed_state_t;

  function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned width);
    return lane * width;
  endfunction

endpackage

// File: rtl/systolic_feed_ctrl_lane.sv
// Per-lane write-enable / zero-select decode for one row or column FIFO.
// Lane LANE gets LANE leading zeros and N-LANE trailing zeros around the data.
module feed_lane_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int unsigned N    = FEED_N_DEF,
  parameter int unsigned LANE = 0,
  parameter int unsigned CW   = 4
) (
  input  feed_state_t   state,
  input  logic [CW-1:0] cnt,
  input  logic          in_valid,
  output logic          w_en,
  output logic          zero_sel
);

  always_comb begin
    w_en     = 1'b0;
    zero_sel = 1'b1;
    unique case (state)
      PRE:  w_en = (cnt < CW'(LANE));
      LOAD: begin
        w_en     = in_valid;
        zero_sel = 1'b0;
      end
      POST: w_en = (cnt < CW'(N - LANE));
      default: ;
    endcase
  end

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Feed sequencer for the NxN MAC array: writes skewed operands into the
// row/column FIFOs, streams them out in lock-step, then waits for drain.
module systolic_feed_ctrl
  import systolic_feed_ctrl_pkg::*;
#(
  parameter int unsigned N            = FEED_N_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned DRAIN_CYCLES = 2 * N + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [$clog2(DEPTH+1)-1:0]   k_len,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N*DATA_WIDTH-1:0]      a_data,
  input  logic [N*DATA_WIDTH-1:0]      b_data,
  output logic [N*DATA_WIDTH-1:0]      row_wdata,
  output logic [N*DATA_WIDTH-1:0]      col_wdata,
  output logic [N-1:0]                 row_w_en,
  output logic [N-1:0]                 col_w_en,
  output logic [N-1:0]                 row_r_en,
  output logic [N-1:0]                 col_r_en,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned KW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(DEPTH + DRAIN_CYCLES + 1);
  localparam logic [KW-1:0] K_MAX = KW'(DEPTH - N);

  feed_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [KW-1:0] k_q, k_n;
  logic [CW-1:0] k_ext;
  logic          done_n, err_n;

  assign k_ext = CW'(k_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      k_q   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      k_q   <= k_n;
      done  <= done_n;
      err   <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    k_n     = k_q;
    done_n  = 1'b0;
    err_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (start) begin
          if (k_len == '0 || k_len > K_MAX) begin
            err_n = 1'b1;
          end else begin
            k_n     = k_len;
            state_n = (N > 1) ? PRE : LOAD;
          end
        end
      end
      PRE: begin
        if (cnt == CW'(N - 2)) begin
          state_n = LOAD;
          cnt_n   = '0;
        end
      end
      // cnt here counts accepted beats, so it only advances on in_valid
      LOAD: begin
        cnt_n = cnt;
        if (in_valid) begin
          if (cnt == k_ext - CW'(1)) begin
            state_n = POST;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      POST: begin
        if (cnt == CW'(N - 1)) begin
          state_n = FEED;
          cnt_n   = '0;
        end
      end
      FEED: begin
        if (cnt == k_ext + CW'(N - 1)) begin
          state_n = DRAIN;
          cnt_n   = '0;
        end
      end
      DRAIN: begin
        if (cnt == CW'(DRAIN_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          done_n  = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign in_ready = (state == LOAD);
  assign busy     = (state != IDLE);
  assign row_r_en = {N{state == FEED}};
  assign col_r_en = {N{state == FEED}};

  for (genvar g = 0; g < N; g++) begin : g_lane
    logic row_zero, col_zero;

    feed_lane_ctrl #(.N(N), .LANE(g), .CW(CW)) u_row (
      .state    (state),
      .cnt      (cnt),
      .in_valid (in_valid),
      .w_en     (row_w_en[g]),
      .zero_sel (row_zero)
    );

    feed_lane_ctrl #(.N(N), .LANE(g), .CW(CW)) u_col (
      .state    (state),
      .cnt      (cnt),
      .in_valid (in_valid),
      .w_en     (col_w_en[g]),
      .zero_sel (col_zero)
    );

    assign row_wdata[lane_lo(g, DATA_WIDTH) +: DATA_WIDTH] =
      row_zero ? '0 : a_data[lane_lo(g, DATA_WIDTH) +: DATA_WIDTH];
    assign col_wdata[lane_lo(g, DATA_WIDTH) +: DATA_WIDTH] =
      col_zero ? '0 : b_data[lane_lo(g, DATA_WIDTH) +: DATA_WIDTH];
  end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Bench for systolic_feed_ctrl: FIFO + PE-grid model driven by the DUT
// enables, with a per-lane scoreboard of expected FIFO writes.
module tb_systolic_feed_ctrl;

  localparam int N     = 3;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int DRAIN = 2 * N + 1;
  localparam int KW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst, start, in_valid;
  logic [KW-1:0]   k_len;
  logic [N*DW-1:0] a_data, b_data, row_wdata, col_wdata;
  logic [N-1:0]    row_w_en, col_w_en, row_r_en, col_r_en;
  logic            in_ready, busy, done, err;

  always #5 clk = ~clk;

  systolic_feed_ctrl #(
    .N(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_data(a_data), .b_data(b_data),
    .row_wdata(row_wdata), .col_wdata(col_wdata),
    .row_w_en(row_w_en), .col_w_en(col_w_en),
    .row_r_en(row_r_en), .col_r_en(col_r_en),
    .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Lanes 0..N-1 are row FIFOs, N..2N-1 are column FIFOs.
  logic [DW-1:0] exp_q  [2*N][$];
  logic [DW-1:0] fifo_q [2*N][$];
  logic [DW-1:0] dout   [2*N];
  longint        a_pipe [N][N];
  longint        b_pipe [N][N];
  longint        acc    [N][N];
  int            mat_a  [N][DEPTH];
  int            mat_b  [DEPTH][N];
  int            load_wr, en_seen, cur_k;
  bit            prev_feed;

  initial begin : monitor
    logic          we, re;
    logic [DW-1:0] wd;
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int l = 0; l < 2*N; l++) begin
          fifo_q[l].delete();
          dout[l] = '0;
        end
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            a_pipe[i][j] = 0; b_pipe[i][j] = 0; acc[i][j] = 0;
          end
        prev_feed = 1'b0;
      end else begin
        if (|{row_w_en, col_w_en, row_r_en, col_r_en}) en_seen++;
        if (in_ready && row_w_en[0]) load_wr++;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] += a_pipe[i][j] * b_pipe[i][j];
        for (int i = 0; i < N; i++) begin
          for (int j = N - 1; j > 0; j--) a_pipe[i][j] = a_pipe[i][j-1];
          a_pipe[i][0] = longint'(dout[i]);
        end
        for (int j = 0; j < N; j++) begin
          for (int i = N - 1; i > 0; i--) b_pipe[i][j] = b_pipe[i-1][j];
          b_pipe[0][j] = longint'(dout[N+j]);
        end
        if (row_r_en[0] && !prev_feed) begin
          for (int l = 0; l < 2*N; l++) begin
            chk($sformatf("fill%0d", l), fifo_q[l].size(), cur_k + N);
            chk($sformatf("full_at_feed%0d", l), fifo_q[l].size() == DEPTH, cur_k == DEPTH - N);
          end
        end
        prev_feed = row_r_en[0];
        for (int l = 0; l < 2*N; l++) begin
          we = (l < N) ? row_w_en[l] : col_w_en[l-N];
          re = (l < N) ? row_r_en[l] : col_r_en[l-N];
          wd = (l < N) ? row_wdata[l*DW +: DW] : col_wdata[(l-N)*DW +: DW];
          if (we) begin
            chk($sformatf("wr_while_full%0d", l), fifo_q[l].size() < DEPTH, 1);
            if (exp_q[l].size() == 0) chk($sformatf("wr_unexpected%0d", l), 0, 1);
            else chk($sformatf("wdata%0d", l), wd, exp_q[l].pop_front());
            fifo_q[l].push_back(wd);
          end
          if (re) begin
            chk($sformatf("rd_empty%0d", l), fifo_q[l].size() != 0, 1);
            if (fifo_q[l].size() != 0) dout[l] = fifo_q[l].pop_front();
          end
        end
      end
    end
  end

  function automatic int lat_exp(input int k, input int stall);
    return (N - 1) + k + N + (k + N) + DRAIN + stall * (k - 1);
  endfunction

  task automatic check_products();
    longint e;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        e = 0;
        for (int kk = 0; kk < cur_k; kk++) e += mat_a[i][kk] * mat_b[kk][j];
        chk($sformatf("c%0d%0d", i, j), acc[i][j], e);
      end
  endtask

  task automatic run_tile(input int k, input int stall, input bit abort);
    int  s, g;
    bit  ok;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        a_pipe[i][j] = 0; b_pipe[i][j] = 0; acc[i][j] = 0;
      end
    cur_k   = k;
    load_wr = 0;
    for (int l = 0; l < 2*N; l++)
      for (int z = 0; z < l % N; z++) exp_q[l].push_back('0);
    k_len = KW'(k);
    start = 1'b1;
    s     = cyc + 1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int kk = 0; kk < k; kk++) begin
      for (int i = 0; i < N; i++) begin
        a_data[i*DW +: DW] = DW'(mat_a[i][kk]);
        b_data[i*DW +: DW] = DW'(mat_b[kk][i]);
        exp_q[i].push_back(DW'(mat_a[i][kk]));
        exp_q[N+i].push_back(DW'(mat_b[kk][i]));
      end
      in_valid = 1'b1;
      ok = 1'b0;
      g  = 0;
      while (!ok && g < 50) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk); #1;
        g++;
      end
      chk("beat_accept", ok, 1);
      in_valid = 1'b0;
      if (kk < k - 1) repeat (stall) begin @(posedge clk); #1; end
    end
    for (int l = 0; l < 2*N; l++)
      for (int z = 0; z < N - (l % N); z++) exp_q[l].push_back('0);
    if (abort) begin
      g = 0;
      do begin @(negedge clk); g++; end while (!row_r_en[0] && g < 50);
      chk("feed_reached", row_r_en[0], 1);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      chk("rst_r_en", {row_r_en, col_r_en}, 0);
      chk("rst_w_en", {row_w_en, col_w_en}, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      for (int l = 0; l < 2*N; l++) exp_q[l].delete();
      @(negedge clk);
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      g = 0;
      do begin @(negedge clk); g++; end while (!done && g < 300);
      chk("done_seen", done, 1);
      chk("done_lat", cyc - s, lat_exp(k, stall));
      chk("idle_at_done", busy, 0);
      chk("load_writes", load_wr, k);
      for (int l = 0; l < 2*N; l++) chk($sformatf("exp_left%0d", l), exp_q[l].size(), 0);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; k_len = '0;
    a_data = '0; b_data = '0;
    en_seen = 0; cur_k = 0; load_wr = 0; prev_feed = 1'b0;

    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_w_en", {row_w_en, col_w_en}, 0);
    chk("rst_r_en", {row_r_en, col_r_en}, 0);
    chk("rst_wdata", {row_wdata, col_wdata}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Identity A times B: products reproduce B.
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < N; kk++) begin
        mat_a[i][kk] = (i == kk) ? 1 : 0;
        mat_b[kk][i] = 3 * kk + i + 1;
      end
    run_tile(3, 0, 1'b0);
    check_products();
    @(negedge clk);
    chk("done_pulse_width", done, 0);

    // Host stalls between beats.
    run_tile(2, 3, 1'b0);
    check_products();

    // Illegal k_len values.
    en_seen = 0;
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      k_len = (t == 0) ? KW'(0) : KW'(6);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk($sformatf("err_pulse_k%0d", k_len), err, 1);
      chk($sformatf("err_busy_k%0d", k_len), busy, 0);
      @(negedge clk);
      chk($sformatf("err_clear_k%0d", k_len), err, 0);
      chk($sformatf("err_idle_k%0d", k_len), busy, 0);
    end
    chk("err_no_enables", en_seen, 0);

    // Reset during FEED cycle 2, then a clean tile.
    run_tile(3, 0, 1'b1);
    run_tile(3, 0, 1'b0);
    check_products();

    // Back-to-back: random tile, then 2s x 3s started right after done.
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 3; kk++) begin
        mat_a[i][kk] = int'($urandom_range(0, 50));
        mat_b[kk][i] = int'($urandom_range(0, 50));
      end
    run_tile(3, 0, 1'b0);
    check_products();
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < 3; kk++) begin
        mat_a[i][kk] = 2;
        mat_b[kk][i] = 3;
      end
    run_tile(3, 0, 1'b0);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        chk($sformatf("b2b_c%0d%0d", i, j), acc[i][j], 18);

    // Deepest legal tile fills every FIFO exactly.
    for (int i = 0; i < N; i++)
      for (int kk = 0; kk < DEPTH - N; kk++) begin
        mat_a[i][kk] = int'($urandom_range(0, 200));
        mat_b[kk][i] = int'($urandom_range(0, 200));
      end
    @(posedge clk); #1;
    run_tile(DEPTH - N, 0, 1'b0);
    check_products();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/systolic_feed_ctrl.md
# systolic_feed_ctrl

Upstream sequencer for the N×N integer MAC systolic array. It accepts one reduction step per host beat (N row operands of A, N column operands of B) and writes them into the array's per-row and per-column input FIFOs, inserting zero padding so that lane i is skewed by i cycles. It then reads all FIFOs in lock-step to stream the operands into the PE grid, waits for the wavefront to drain, and reports completion. It drives the `w_en`, `r_en` and `in_data` inputs of the row/column FIFOs that feed the array.

## Interface
- `N`, 3: array dimension; number of row lanes and number of column lanes.
- `DATA_WIDTH`, 16: operand width.
- `DEPTH`, 8: FIFO depth; must be ≥ N+1.
- `DRAIN_CYCLES`, 2*N+1: wait cycles after the last read before `done`.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: begin a tile; sampled only in IDLE.
- `k_len` in $clog2(DEPTH+1): reduction length; sampled with `start`.
- `in_valid` in 1: host beat valid.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `a_data` in N*DATA_WIDTH: lane i = A[i][k], bits [i*DW +: DW].
- `b_data` in N*DATA_WIDTH: lane j = B[k][j].
- `row_wdata` / `col_wdata` out N*DATA_WIDTH: FIFO write data, one lane per FIFO.
- `row_w_en` / `col_w_en` out N: FIFO write enables.
- `row_r_en` / `col_r_en` out N: FIFO read enables.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: single-cycle pulse when a tile completes.
- `err` out 1: single-cycle pulse when `start` is rejected.

## Operation
- Legal `k_len` range is 1..DEPTH−N. If `start` arrives with `k_len` = 0 or `k_len` > DEPTH−N: `err` pulses the next cycle and the block stays in IDLE.
- States: IDLE → PRE → LOAD → POST → FEED → DRAIN → IDLE. A single counter `cnt` is cleared on every state entry.
- **PRE** (N−1 cycles; skipped when N=1):
  - Lane i write enable is high while `cnt < i`.
  - Write data is 0.
  - Result: FIFO i holds i leading zeros.
- **LOAD**:
  - `in_ready` = 1.
  - On each accepted beat, all row and column w_en are high and wdata = `a_data`/`b_data` lanes.
  - `in_valid` low means a stall cycle with no writes.
  - Exits after `k_len` accepted beats.
- **POST** (N cycles):
  - Lane i write enable is high while `cnt < N−i`.
  - Write data is 0.
  - Each FIFO now holds exactly `k_len`+N entries, and its last entry is 0. The FIFO output therefore holds 0 after the final read and never re-multiplies stale data.
- **FEED** (`k_len`+N cycles): all r_en high; no writes.
- **DRAIN** (DRAIN_CYCLES cycles): all enables low.
- On DRAIN exit, `done` pulses for one cycle coincident with the return to IDLE. `start` is ignored outside IDLE.
- w_en/r_en/wdata/`in_ready` are decoded from the state and `cnt` registers. The only exception is LOAD-state w_en, which is gated combinationally by `in_valid`.
- Counter width is $clog2(DEPTH+DRAIN_CYCLES+1). No arithmetic on data; operands pass through unmodified.

## Timing
- Reset values:
  - state IDLE, `cnt` 0.
  - `in_ready`, `busy`, `done` and `err` all 0.
  - All w_en and r_en 0; all wdata 0.
- `rst` asserted mid-tile returns the block to IDLE asynchronously with all enables low. Partial FIFO contents are the owner's responsibility; the FIFOs share the reset.
- `start` seen at edge t: `busy` = 1 from t+1, and PRE occupies t+1..t+N−1.
- Minimum tile time (`in_valid` held high): (N−1) + k + N + (k+N) + DRAIN_CYCLES cycles from `start` to the `done` pulse. For N=3, k=3: 2+3+3+6+7 = 21.
- Back-to-back: `start` is accepted in the cycle after `done`.

## Structure
- Shared package holds:
  - the state enum `feed_state_t` (IDLE, PRE, LOAD, POST, FEED, DRAIN);
  - the lane-slice helper constants.
- The same package holds DATA_WIDTH/DEPTH defaults, so they are common with the FIFO and PE.
- Natural sub-module: `feed_lane_ctrl`, one instance per lane index. It decodes that lane's w_en and zero-select from state, `cnt` and lane index. It is instantiated for rows and columns.

## Test plan
- **Identity check**, N=3, k=3: A = identity, B = [[1,2,3],[4,5,6],[7,8,9]], `in_valid` continuous.
  - `done` pulses 21 cycles after `start`.
  - Array outputs equal B.
  - Write log for FIFO 2 is 0,0,a,a,a,0; for FIFO 0 it is a,a,a,0,0,0.
- **Host stalls**: k=2 with `in_valid` low for 3 cycles between beats.
  - Exactly 2 LOAD writes occur.
  - `done` arrives 3 cycles later than with no stalls.
  - Products unchanged.
- **Illegal `k_len`**: `k_len` = 0 and `k_len` = 6 (DEPTH=8, N=3).
  - `err` pulses 1 cycle later.
  - `busy` stays 0 and no enables toggle.
- **Reset mid-FEED**: assert `rst` during FEED cycle 2.
  - All r_en/w_en drop immediately; `busy` = 0.
  - A following legal tile completes correctly.
- **Back-to-back tiles**: `start` in the cycle after `done` with new A/B (all 2s × all 3s, k=3).
  - The second tile's outputs equal 18 in every PE, counted from reset-cleared accumulators.
- **No FIFO overflow**: k = DEPTH−N = 5.
  - FIFO `full` is asserted exactly at the end of POST.
  - No write occurs while `full` = 1.
